tm1637_sequencer: RTL and testbench

Upstream command sequencer for the TM1637 LED display path. Turns four hex digits and a brightness setting into the TM1637 three-frame write sequence (data command, address plus 4 segment bytes, display control) and feeds it byte by byte into `spi_master` over its `data_in`/`wr`/`buffempty`/`ss` interface. It refreshes the display periodically or on request, so top level only drives digit values.

---
 rtl/tm1637_pkg.sv | 33 +++
 rtl/tm1637_sequencer_hex7seg.sv | 14 +
 rtl/tm1637_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_tm1637_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1637_pkg.sv
// TM1637 command constants, sequencer state encoding and the hex segment table.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package tm1637_pkg;

    localparam logic [7:0] CMD_DATA_AUTO = 8'h40;  // data write, auto-increment address
    localparam logic [7:0] CMD_ADDR0     = 8'hC0;  // set address 0
    localparam logic [7:0] CMD_DISP_ON   = 8'h88;  // display on, brightness in [2:0]
    localparam logic [7:0] CMD_DISP_OFF  = 8'h80;  // display off

    localparam logic [2:0] LAST_BYTE_IDX = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        ACK,
        WAIT_SS,
        GAP
    } state_t;

    // gfedcba segment patterns, entry [n] is hex digit n; bit7 (colon/dp) is clear.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    // Bytes 0, 5 and 6 close a frame; the master must release ss after them.
    function automatic logic is_frame_end(input logic [2:0] idx);
        return (idx == 3'd0) || (idx == 3'd5) || (idx == LAST_BYTE_IDX);
    endfunction

endpackage

// File: rtl/tm1637_sequencer_hex7seg.sv
// Hex nibble to TM1637 segment byte decoder.
// Latency: combinational.
// Backpressure: none.
// Ports: nibble - hex digit in; seg - gfedcba segment byte out (bit7 = 0).
module hex7seg
    import tm1637_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/tm1637_sequencer.sv
// Builds the TM1637 write sequence (data cmd | addr + 4 segments | display ctrl) and feeds spi_master byte by byte.
// Latency: first spi_wr rise 2 cycles after the trigger cycle; one frame gap of GAP_CYCLES after each ss release.
// Backpressure: a byte is issued only when synchronised buffempty is high; requests while busy collapse into one pending refresh.
//
// Ports: clk/rst (async, active-high); digits/brightness/display_on/update from top level;
//        spi_data/spi_wr to the master, spi_buffempty/spi_ss back from it (double-flop synchronised);
//        busy while a sequence runs, seq_done one-cycle pulse at the end.
// Build option: define TM1637_COLON_EN to add the colon input, which sets bit7 of the digit-1 segment byte.
module tm1637_sequencer
    import tm1637_pkg::*;
#(
    parameter int REFRESH_CYCLES = 2_500_000,
    parameter int GAP_CYCLES     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [2:0]  brightness,
    input  logic        display_on,
    input  logic        update,
`ifdef TM1637_COLON_EN
    input  logic        colon,
`endif
    output logic [7:0]  spi_data,
    output logic        spi_wr,
    input  logic        spi_buffempty,
    input  logic        spi_ss,
    output logic        busy,
    output logic        seq_done
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int CW = $clog2(GAP_CYCLES + 2);

    // ---------------- handshake synchronisers ----------------
    logic be_meta, be_sync;
    logic ss_meta, ss_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            be_meta <= 1'b0;
            be_sync <= 1'b0;
            ss_meta <= 1'b0;
            ss_sync <= 1'b0;
        end else begin
            be_meta <= spi_buffempty;
            be_sync <= be_meta;
            ss_meta <= spi_ss;
            ss_sync <= ss_meta;
        end
    end

    // ---------------- refresh counter ----------------
    logic [RW-1:0] refresh_cnt;
    logic          refresh_expiry;

    assign refresh_expiry = (REFRESH_CYCLES != 0) && (refresh_cnt == RW'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
        end else if (refresh_expiry || (REFRESH_CYCLES == 0)) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // ---------------- sequencer state ----------------
    state_t        state;
    logic [2:0]    byte_idx;
    logic [CW-1:0] cnt;
    logic          pending;
    logic [15:0]   snap_digits;
    logic [2:0]    snap_bright;
    logic          snap_on;
`ifdef TM1637_COLON_EN
    logic          snap_colon;
`endif

    // Index of the byte about to be loaded: 0 when starting, otherwise the one after byte_idx.
    // spi_data is registered on entry to LOAD so it is stable a full cycle before spi_wr rises.
    logic [2:0] load_idx;
    logic [3:0] nibble;
    logic [7:0] seg_byte;
    logic [7:0] load_byte;

    assign load_idx = (state == IDLE) ? 3'd0 : byte_idx + 3'd1;

    always_comb begin
        nibble = snap_digits[15:12];
        case (load_idx)
            3'd2:    nibble = snap_digits[3:0];
            3'd3:    nibble = snap_digits[7:4];
            3'd4:    nibble = snap_digits[11:8];
            default: nibble = snap_digits[15:12];
        endcase
    end

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (seg_byte)
    );

    always_comb begin
        load_byte = seg_byte;
        case (load_idx)
            3'd0:    load_byte = CMD_DATA_AUTO;
            3'd1:    load_byte = CMD_ADDR0;
            3'd6:    load_byte = snap_on ? (CMD_DISP_ON | {5'b0, snap_bright}) : CMD_DISP_OFF;
            default: load_byte = seg_byte;
        endcase
`ifdef TM1637_COLON_EN
        if ((load_idx == 3'd3) && snap_colon) begin
            load_byte[7] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            byte_idx    <= 3'd0;
            cnt         <= '0;
            pending     <= 1'b0;
            snap_digits <= 16'h0000;
            snap_bright <= 3'd0;
            snap_on     <= 1'b0;
`ifdef TM1637_COLON_EN
            snap_colon  <= 1'b0;
`endif
            spi_data    <= 8'h00;
            spi_wr      <= 1'b0;
            busy        <= 1'b0;
            seq_done    <= 1'b0;
        end else begin
            seq_done <= 1'b0;

            // Any number of requests during a sequence collapse into one follow-up.
            if ((state != IDLE) && (update || refresh_expiry)) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (update || refresh_expiry || pending) begin
                        pending     <= 1'b0;
                        snap_digits <= digits;
                        snap_bright <= brightness;
                        snap_on     <= display_on;
`ifdef TM1637_COLON_EN
                        snap_colon  <= colon;
`endif
                        byte_idx    <= 3'd0;
                        spi_data    <= load_byte;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end

                LOAD: begin
                    spi_wr <= 1'b1;
                    cnt    <= '0;
                    state  <= STROBE;
                end

                // spi_wr held high for two cycles.
                STROBE: begin
                    if (cnt == CW'(1)) begin
                        spi_wr <= 1'b0;
                        state  <= ACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // First sample lands 3 cycles after the spi_wr rise, by which time the
                // synchroniser already carries the post-write (low) buffempty.
                ACK: begin
                    if (be_sync) begin
                        if (is_frame_end(byte_idx)) begin
                            state <= WAIT_SS;
                        end else begin
                            byte_idx <= load_idx;
                            spi_data <= load_byte;
                            state    <= LOAD;
                        end
                    end
                end

                WAIT_SS: begin
                    if (ss_sync) begin
                        cnt   <= '0;
                        state <= GAP;
                    end
                end

                GAP: begin
                    if (cnt == CW'(GAP_CYCLES - 1)) begin
                        if (byte_idx < LAST_BYTE_IDX) begin
                            byte_idx <= load_idx;
                            spi_data <= load_byte;
                            state    <= LOAD;
                        end else begin
                            seq_done <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm1637_sequencer.sv
`timescale 1ns/1ps
module tb_tm1637_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic [2:0]  brightness = 3'd0;
    logic        display_on = 1'b0;
    logic        update = 1'b0;
`ifdef TM1637_COLON_EN
    logic        colon = 1'b0;
`endif
    logic [7:0]  spi_data;
    logic        spi_wr;
    logic        spi_buffempty;
    logic        spi_ss;
    logic        busy;
    logic        seq_done;

    tm1637_sequencer #(.REFRESH_CYCLES(5000), .GAP_CYCLES(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .digits        (digits),
        .brightness    (brightness),
        .display_on    (display_on),
        .update        (update),
`ifdef TM1637_COLON_EN
        .colon         (colon),
`endif
        .spi_data      (spi_data),
        .spi_wr        (spi_wr),
        .spi_buffempty (spi_buffempty),
        .spi_ss        (spi_ss),
        .busy          (busy),
        .seq_done      (seq_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    int frm_q[$];
    int done_cnt = 0;
    int exp_done = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- spi_master model ----------------
    // Single holding buffer captured on the spi_wr rise; shift register drained one bit per
    // master tick (every mdiv clk cycles). ss stays low while bytes keep arriving.
    int   wr_cnt = 0;
    int   take_cnt = 0;
    logic senderr = 1'b0;
    int   mdiv = 1;
    int   tick = 0;
    int   bits = 0;
    int   frame_n = 0;
    int   frame_len = 0;
    logic shifting = 1'b0;
    logic stall = 1'b0;
    logic frame_evt = 1'b0;
    logic ss_r = 1'b1;

    assign spi_buffempty = (wr_cnt == take_cnt);
    assign spi_ss = ss_r;

    always @(posedge spi_wr) begin
        if (wr_cnt != take_cnt) senderr = 1'b1;
        wr_cnt = wr_cnt + 1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            take_cnt  <= wr_cnt;
            shifting  <= 1'b0;
            bits      <= 0;
            ss_r      <= 1'b1;
            frame_n   <= 0;
            frame_evt <= 1'b0;
            tick      <= 0;
        end else begin
            frame_evt <= 1'b0;
            if (tick >= mdiv - 1) begin
                tick <= 0;
                if (shifting) begin
                    if (bits == 7) begin
                        bits <= 0;
                        if (wr_cnt != take_cnt && !stall) begin
                            take_cnt <= take_cnt + 1;
                            frame_n  <= frame_n + 1;
                        end else begin
                            shifting  <= 1'b0;
                            ss_r      <= 1'b1;
                            frame_evt <= 1'b1;
                            frame_len <= frame_n;
                            frame_n   <= 0;
                        end
                    end else begin
                        bits <= bits + 1;
                    end
                end else if (wr_cnt != take_cnt && !stall) begin
                    shifting <= 1'b1;
                    ss_r     <= 1'b0;
                    take_cnt <= take_cnt + 1;
                    frame_n  <= 1;
                    bits     <= 0;
                end
            end else begin
                tick <= tick + 1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic       wr_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        int         f;
        if (!rst) begin
            if (spi_wr && !wr_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL byte_unexpected got=%02h expected=none", spi_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", spi_data, e);
                end
                check("data_setup", spi_data, data_prev);
            end
            if (frame_evt) begin
                if (frm_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL frame_unexpected got=%0d expected=none", frame_len);
                end else begin
                    f = frm_q.pop_front();
                    check("frame_len", frame_len, f);
                end
            end
            if (seq_done) done_cnt++;
        end
        wr_prev   <= spi_wr;
        data_prev <= spi_data;
    end

    // ---------------- stimulus helpers ----------------
    task automatic push7(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                         input logic [7:0] b6);
        exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2); exp_q.push_back(b3);
        exp_q.push_back(b4); exp_q.push_back(b5); exp_q.push_back(b6);
        frm_q.push_back(1); frm_q.push_back(5); frm_q.push_back(1);
        exp_done++;
    endtask

    task automatic pulse_update();
        @(negedge clk) update = 1'b1;
        @(negedge clk) update = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0 || frm_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=busy%0d/bytes_left%0d expected=idle", name, busy, exp_q.size());
        end
        check({name, "_done_cnt"}, done_cnt, exp_done);
    endtask

    task automatic wait_wr(input string name, input int budget, output int n);
        n = 0;
        while (!spi_wr && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!spi_wr) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=no_spi_wr expected=spi_wr within %0d", name, budget);
        end
    endtask

    logic [7:0] colon_b3;
    int n, r0, r1, rises;
    logic wp;

    initial begin
`ifdef TM1637_COLON_EN
        colon_b3 = 8'hFF;
`else
        colon_b3 = 8'h7F;
`endif
        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_spi_wr", spi_wr, 1'b0);
        check("rst_spi_data", spi_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_seq_done", seq_done, 1'b0);
        rst = 1'b0;

        // ---- full sequence, 0x3210, brightness 7, on ----
        digits = 16'h3210; brightness = 3'd7; display_on = 1'b1;
        push7(8'h40, 8'hC0, 8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h8F);
        @(negedge clk) update = 1'b1;
        @(negedge clk) update = 1'b0;
        check("lat_wr_cycle1", spi_wr, 1'b0);
        check("busy_start", busy, 1'b1);
        check("lat_data_byte0", spi_data, 8'h40);
        @(negedge clk);
        check("lat_wr_cycle2", spi_wr, 1'b1);
        wait_done("full", 3000);

        // ---- reset during STROBE, then replay ----
        do_reset();
        exp_q.push_back(8'h40);
        pulse_update();
        n = 0;
        while (!spi_wr && n < 20) begin @(negedge clk); n++; end
        check("strobe_reached", spi_wr, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_spi_wr", spi_wr, 1'b0);
        check("midrst_spi_data", spi_data, 8'h00);
        check("midrst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        digits = 16'h7654; brightness = 3'd0; display_on = 1'b1;
        push7(8'h40, 8'hC0, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h88);
        pulse_update();
        wait_done("replay", 3000);

        // ---- display off, all-F digits ----
        do_reset();
        digits = 16'hFFFF; brightness = 3'd5; display_on = 1'b0;
        push7(8'h40, 8'hC0, 8'h71, 8'h71, 8'h71, 8'h71, 8'h80);
        pulse_update();
        wait_done("off", 3000);

        // ---- requests while busy collapse to one follow-up with new values ----
        do_reset();
        digits = 16'h3210; brightness = 3'd7; display_on = 1'b1;
        push7(8'h40, 8'hC0, 8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h8F);
        push7(8'h40, 8'hC0, 8'h71, 8'h79, 8'h79, 8'h7C, 8'h8A);
        pulse_update();
        repeat (50) @(negedge clk);
        check("busy_req1", busy, 1'b1);
        digits = 16'hBEEF; brightness = 3'd2;
        pulse_update();
        repeat (60) @(negedge clk);
        check("busy_req2", busy, 1'b1);
        pulse_update();
        repeat (60) @(negedge clk);
        check("busy_req3", busy, 1'b1);
        pulse_update();
        wait_done("pending", 6000);

        // ---- 0x8888 (colon byte when enabled), normal then 1/7-rate master ----
        for (int k = 0; k < 2; k++) begin
            do_reset();
            mdiv = (k == 0) ? 1 : 7;
`ifdef TM1637_COLON_EN
            colon = 1'b1;
`endif
            digits = 16'h8888; brightness = 3'd7; display_on = 1'b1;
            push7(8'h40, 8'hC0, 8'h7F, colon_b3, 8'h7F, 8'h7F, 8'h8F);
            pulse_update();
            wait_done("eights", 4500);
        end
        mdiv = 1;

        // ---- auto-refresh every 5000 cycles ----
        do_reset();
        digits = 16'hC0DE; brightness = 3'd4; display_on = 1'b1;
        push7(8'h40, 8'hC0, 8'h79, 8'h5E, 8'h3F, 8'h39, 8'h8C);
        wait_wr("refresh1", 6000, n);
        check("refresh_first_wr", n, 5001);
        r0 = cyc;
        wait_done("refresh1", 2000);
        push7(8'h40, 8'hC0, 8'h79, 8'h5E, 8'h3F, 8'h39, 8'h8C);
        wait_wr("refresh2", 6000, n);
        r1 = cyc;
        check("refresh_period", r1 - r0, 5000);
        wait_done("refresh2", 2000);

        // ---- buffempty stalled low: no further writes, then resume plus one pending ----
        stall = 1'b1;
        push7(8'h40, 8'hC0, 8'h79, 8'h5E, 8'h3F, 8'h39, 8'h8C);
        push7(8'h40, 8'hC0, 8'h79, 8'h5E, 8'h3F, 8'h39, 8'h8C);
        wait_wr("stall", 6000, n);
        rises = 0;
        wp = spi_wr;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (spi_wr && !wp) rises++;
            wp = spi_wr;
        end
        check("stall_no_wr", rises, 0);
        check("stall_busy", busy, 1'b1);
        stall = 1'b0;
        wait_done("stall", 4000);

        do_reset();
        check("no_senderr", senderr, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
